// File: rtl/ser_frame_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB-first, optional even parity, stop bit.
// Optional parity bit is compiled in with the macro SER_FRAME_TX_PARITY_EN.
module ser_frame_tx #(
    parameter int WIDTH  = 8,
    parameter int CLKDIV = 4
) (
    input  logic             main_clk_i,
    input  logic             main_rst_i,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic             ser_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
    localparam logic [15:0]   DIV_RELOAD = 16'(CLKDIV - 1);

    // Handshake: a word moves when tx_valid_i && tx_ready_o at a rising edge;
    // tx_ready_o depends only on the registered state.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SER_FRAME_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]      div_cnt_q, div_cnt_d;
    logic             ser_q, ser_d;
    logic             done_q, done_d;
    logic             bit_end;
`ifdef SER_FRAME_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        done_d    = 1'b0;
`ifdef SER_FRAME_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        bit_end   = (div_cnt_q == 16'd0);

        // Bit-period counter reloads on every bit boundary, so CLKDIV=1 never underflows.
        if (state_q != IDLE) begin
            if (bit_end) begin
                div_cnt_d = DIV_RELOAD;
            end else begin
                div_cnt_d = div_cnt_q - 16'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (tx_valid_i) begin
                    state_d   = START;
                    shift_d   = tx_data_i;
                    bit_cnt_d = '0;
                    div_cnt_d = DIV_RELOAD;
`ifdef SER_FRAME_TX_PARITY_EN
                    parity_d  = ^tx_data_i;
`endif
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef SER_FRAME_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
`ifdef SER_FRAME_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so it changes together with it.
        case (state_d)
            START:   ser_d = 1'b0;
            DATA:    ser_d = shift_d[0];
`ifdef SER_FRAME_TX_PARITY_EN
            PARITY:  ser_d = parity_d;
`endif
            default: ser_d = 1'b1;
        endcase
    end

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            ser_q     <= 1'b1;
            done_q    <= 1'b0;
`ifdef SER_FRAME_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            ser_q     <= ser_d;
            done_q    <= done_d;
`ifdef SER_FRAME_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx_ready_o = (state_q == IDLE);
    assign busy_o     = (state_q != IDLE);
    assign ser_o      = ser_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_ser_frame_tx.sv
// Bench for ser_frame_tx: table vectors, random words vs. a frame-level model,
// back-to-back frames at CLKDIV=1, reset abort and reset-suppressed acceptance.
module tb_ser_frame_tx;
    localparam int W   = 8;
    localparam int DIV = 4;
`ifdef SER_FRAME_TX_PARITY_EN
    localparam int NB = W + 3;
`else
    localparam int NB = W + 2;
`endif
    localparam int FLEN = NB * DIV;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_data, b_data;
    logic         a_valid, b_valid;
    logic         a_ready, a_ser, a_busy, a_done;
    logic         b_ready, b_ser, b_busy, b_done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [0:0] exp_q[$];

    typedef struct {
        logic [W-1:0] data;
        logic [10:0]  frame_np;
        logic [10:0]  frame_p;
    } vec_t;
    vec_t vecs[5];

    ser_frame_tx #(.WIDTH(W), .CLKDIV(DIV)) u_dut (
        .main_clk_i(clk), .main_rst_i(rst), .tx_data_i(a_data), .tx_valid_i(a_valid),
        .tx_ready_o(a_ready), .ser_o(a_ser), .busy_o(a_busy), .done_o(a_done)
    );

    ser_frame_tx #(.WIDTH(W), .CLKDIV(1)) u_dut1 (
        .main_clk_i(clk), .main_rst_i(rst), .tx_data_i(b_data), .tx_valid_i(b_valid),
        .tx_ready_o(b_ready), .ser_o(b_ser), .busy_o(b_busy), .done_o(b_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Line levels of one frame, one entry per clock cycle.
    task automatic model_frame(input logic [W-1:0] w, input int div);
        logic bits[$];
        exp_q.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(w[i]);
`ifdef SER_FRAME_TX_PARITY_EN
        bits.push_back(^w);
`endif
        bits.push_back(1'b1);
        foreach (bits[b]) for (int k = 0; k < div; k++) exp_q.push_back(bits[b]);
    endtask

    task automatic send_a(input logic [W-1:0] w, input bit toggle,
                          output int busy_cnt, output logic [63:0] ser_s);
        int guard = 0;
        int ser_bad = 0;
        int ctl_bad = 0;
        while (a_ready !== 1'b1 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_wait", a_ready, 1);
        model_frame(w, DIV);
        a_data  = w;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid  = 1'b0;
        busy_cnt = 0;
        ser_s    = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (a_ser !== exp_q[i]) ser_bad++;
            ser_s[i] = a_ser;
            if (a_busy === 1'b1) busy_cnt++;
            if (a_done !== 1'b0 || a_ready !== 1'b0) ctl_bad++;
            if (toggle) a_data = W'($urandom);
        end
        @(negedge clk);
        check("frame_ser", ser_bad, 0);
        check("frame_ctl", ctl_bad, 0);
        check("done_pulse", a_done, 1);
        check("idle_ser", a_ser, 1);
        check("idle_busy", a_busy, 0);
        @(posedge clk); #1;
        check("done_once", a_done, 0);
    endtask

    initial begin
        int          bc;
        logic [63:0] ss;
        logic [10:0] got, expf;
        logic [W-1:0] bw[3];
        logic [0:0]  t_ser[$];
        logic [0:0]  t_rdy[$];
        logic [0:0]  t_done[$];
        int          acc[3];
        int          k, sb, rb, bb, db, bad;

        vecs[0] = '{8'hA5, 11'h34A, 11'h54A};
        vecs[1] = '{8'h01, 11'h202, 11'h602};
        vecs[2] = '{8'h00, 11'h200, 11'h400};
        vecs[3] = '{8'hFF, 11'h3FE, 11'h5FE};
        vecs[4] = '{8'h80, 11'h300, 11'h700};

        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ser", a_ser, 1);
        check("rst_ready", a_ready, 1);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_ser_b", b_ser, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            send_a(vecs[i].data, 1'b0, bc, ss);
            check("tbl_busy_len", bc, FLEN);
            got = '0;
            for (int b = 0; b < NB; b++) got[b] = ss[b*DIV + DIV/2];
`ifdef SER_FRAME_TX_PARITY_EN
            expf = vecs[i].frame_p;
`else
            expf = vecs[i].frame_np;
`endif
            check("tbl_frame", got, expf);
        end

        for (int i = 0; i < 15; i++) begin
            send_a(W'($urandom), 1'b1, bc, ss);
            check("rnd_busy_len", bc, FLEN);
        end

        // Reset during data bit 3 aborts the frame.
        a_data = 8'h3C; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        a_data  = 8'hC3;
        repeat (17) @(posedge clk);
        #1;
        check("pre_rst_busy", a_busy, 1);
        check("pre_rst_bit3", a_ser, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ser", a_ser, 1);
        check("abort_ready", a_ready, 1);
        check("abort_busy", a_busy, 0);
        check("abort_done", a_done, 0);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (a_done !== 1'b0 || a_ser !== 1'b1 || a_busy !== 1'b0) bad++;
        end
        check("abort_quiet", bad, 0);
        @(posedge clk); #1;
        send_a(8'h5A, 1'b1, bc, ss);
        check("post_rst_len", bc, FLEN);

        // A word offered while reset is high is not accepted.
        rst = 1'b1; a_valid = 1'b1; a_data = 8'h77;
        @(posedge clk); #1;
        rst = 1'b0; a_valid = 1'b0;
        check("rst_accept_busy", a_busy, 0);
        @(posedge clk); #1;
        check("rst_accept_busy2", a_busy, 0);
        check("rst_accept_ser", a_ser, 1);

        // Back-to-back frames at CLKDIV=1 with valid held high.
        for (int j = 0; j < 3; j++) bw[j] = W'($urandom);
        t_ser.push_back(1'b1); t_rdy.push_back(1'b1); t_done.push_back(1'b0);
        for (int j = 0; j < 3; j++) begin
            model_frame(bw[j], 1);
            foreach (exp_q[i]) begin
                t_ser.push_back(exp_q[i]); t_rdy.push_back(1'b0); t_done.push_back(1'b0);
            end
            t_ser.push_back(1'b1); t_rdy.push_back(1'b1); t_done.push_back(1'b1);
        end
        t_ser.push_back(1'b1); t_rdy.push_back(1'b1); t_done.push_back(1'b0);

        b_valid = 1'b1; b_data = bw[0];
        k = 0; sb = 0; rb = 0; bb = 0; db = 0;
        for (int c = 0; c < t_ser.size(); c++) begin
            @(negedge clk);
            if (b_ser !== t_ser[c]) sb++;
            if (b_ready !== t_rdy[c]) rb++;
            if (b_busy !== ~t_rdy[c]) bb++;
            if (b_done !== t_done[c]) db++;
            if (b_ready === 1'b1 && b_valid === 1'b1 && k < 3) begin
                acc[k] = c;
                k++;
            end
            @(posedge clk); #1;
            if (k < 3) b_data = bw[k];
            else b_valid = 1'b0;
        end
        check("b2b_ser", sb, 0);
        check("b2b_ready", rb, 0);
        check("b2b_busy", bb, 0);
        check("b2b_done", db, 0);
        check("b2b_accepts", k, 3);
        check("b2b_third_at", acc[2], 2 * (NB + 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
